// File: rtl/sha256_msg_loader.sv
// Byte-stream front end for SHA-256: packs message bytes into 512-bit blocks,
// applies FIPS 180-4 padding and hands blocks downstream tagged first/last.
module sha256_msg_loader #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic {FILL, EMIT} state_t;

  state_t             r_state;
  logic [511:0]       r_buf;
  logic [5:0]         r_idx;
  logic [LEN_W-1:0]   r_count;
  logic               r_first_f;
  logic               r_last_f;
  logic               r_extra_pend;
  logic               r_extra_80;

  logic               w_accept;
  logic [LEN_W-1:0]   w_count_nxt;
  logic [511:0]       w_fill_buf;

  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
    return 64'({c, 3'b000});
  endfunction

  assign w_accept    = in_valid && (r_state == FILL);
  assign w_count_nxt = r_count + LEN_W'(1);

  // Buffer image after accepting the current byte, including in-block padding.
  always_comb begin
    w_fill_buf = r_buf;
    for (int s = 0; s < 64; s++) begin
      if (6'(s) == r_idx)
        w_fill_buf[511-8*s -: 8] = in_data;
      if (in_last && (r_idx <= 6'd62) && (6'(s) == r_idx + 6'd1))
        w_fill_buf[511-8*s -: 8] = 8'h80;
    end
    if (in_last && (r_idx <= 6'd54))
      w_fill_buf[63:0] = bit_len(w_count_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FILL;
      r_buf        <= '0;
      r_idx        <= '0;
      r_count      <= '0;
      r_first_f    <= 1'b1;
      r_last_f     <= 1'b0;
      r_extra_pend <= 1'b0;
      r_extra_80   <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_buf   <= w_fill_buf;
            r_idx   <= r_idx + 6'd1;
            r_count <= w_count_nxt;
            if (in_last) begin
              r_state <= EMIT;
              if (r_idx <= 6'd54) begin
                r_last_f <= 1'b1;
              end else begin
                // Length does not fit: a padding-only block follows.
                r_last_f     <= 1'b0;
                r_extra_pend <= 1'b1;
                r_extra_80   <= (r_idx == 6'd63);
              end
            end else if (r_idx == 6'd63) begin
              r_state  <= EMIT;
              r_last_f <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            r_first_f <= 1'b0;
            if (r_extra_pend) begin
              r_buf        <= {(r_extra_80 ? 8'h80 : 8'h00), 440'b0, bit_len(r_count)};
              r_last_f     <= 1'b1;
              r_extra_pend <= 1'b0;
            end else if (r_last_f) begin
              r_buf     <= '0;
              r_idx     <= '0;
              r_count   <= '0;
              r_last_f  <= 1'b0;
              r_first_f <= 1'b1;
              r_state   <= FILL;
            end else begin
              r_buf   <= '0;
              r_idx   <= '0;
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready  = (r_state == FILL);
  assign blk_valid = (r_state == EMIT);
  assign blk_data  = r_buf;
  assign blk_first = r_first_f && blk_valid;
  assign blk_last  = r_last_f && blk_valid;

endmodule

// File: doc/sha256_msg_loader.md
# sha256_msg_loader

Streaming front end for the SHA-256 datapath. It accepts a message one byte at a time over a valid/ready handshake and assembles 512-bit blocks. It applies the FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Each finished block is presented to the downstream compression stage over a second valid/ready handshake, tagged first/last, so multi-block messages of any length are supported.

## Interface
Parameters:
- LEN_W, 32, width of the internal byte counter. The bit length written into the block is {count, 3'b000} zero-extended to 64 bits. The count wraps modulo 2^LEN_W.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  loader can accept a byte
- in_data  in  8  message byte, in message order
- in_last  in  1  marks the final byte of the message (every message has ≥1 byte)
- blk_valid  out  1  blk_data holds a complete block
- blk_ready  in  1  downstream accepts the block
- blk_data  out  512  block; message byte 0 at [511:504], byte 63 at [7:0]
- blk_first  out  1  first block of a message (downstream reloads initial H)
- blk_last  out  1  final block of a message (downstream publishes the hash)

## Operation
- Two states: FILL and EMIT. in_ready = (state==FILL); blk_valid = (state==EMIT).
- Registers: buffer[511:0], idx[5:0] (next byte slot), count[LEN_W-1:0], first_f, last_f, extra_pend, extra_80.
- FILL, on a byte accept (in_valid && in_ready): write in_data to slot idx, increment idx and count.
  - Not last, idx==63: go to EMIT with last_f=0.
  - in_last, slot k=idx:
    - k≤54: write 0x80 at slot k+1 and the length into [63:0]. last_f=1, go to EMIT.
    - 55≤k≤62: write 0x80 at slot k+1. last_f=0, extra_pend=1, extra_80=0, go to EMIT.
    - k==63: last_f=0, extra_pend=1, extra_80=1, go to EMIT.
  - The length used is the count including the final byte.
- EMIT: hold all block outputs until blk_ready. On the handshake:
  - first_f=0.
  - If extra_pend: load buffer with {extra_80?8'h80:8'h00, zeros, length}. Set last_f=1, clear extra_pend, stay in EMIT.
  - Else if last_f: clear buffer, idx, count and last_f. Set first_f=1, go to FILL.
  - Else: clear buffer and idx, go to FILL.
- Unwritten slots are always zero; the buffer is cleared on every block handoff.
- blk_first = first_f && blk_valid; blk_last = last_f && blk_valid. Both are 0 when blk_valid=0.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state=FILL, so in_ready=1.
  - blk_valid=0, blk_first=0, blk_last=0.
  - blk_data=0, idx=0, count=0, first_f=1, extra_pend=0.
- Reset mid-message discards the partial block and length. The next accepted byte starts a new message.
- Block latency: blk_valid rises the cycle after the accepting edge of byte 63 or of the in_last byte.
- A padding-only block is presented on the cycle after the preceding block's handshake.
- in_ready is a registered-state function with no combinational path from blk_ready or in_valid.
- in_ready is low for the whole of EMIT, so no byte is accepted in the handshake cycle.
- Minimum throughput: 65 cycles per full data block (64 byte accepts + 1 emit cycle).
- Under backpressure (blk_valid && !blk_ready), blk_data, blk_first and blk_last stay stable. The bench checks this every cycle.
- in_data is ignored when in_valid=0. in_last is ignored when no accept occurs.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block:
  - word 0 = 0x61626380, words 1-13 = 0, [63:0]=0x18.
  - first=last=1.
  - It also feeds the existing SHA-256 core, whose digest must equal ba7816bf…f20015ad.
- 55 bytes of 0x41 -> single block: 0x80 at slot 55, length 0x1B8, first=last=1.
- 56 bytes -> two blocks:
  - Block 1: 0x80 at slot 56, slots 57-63 zero, first=1, last=0.
  - Block 2: all zero except [63:0]=0x1C0, first=0, last=1.
- 64 bytes -> two blocks:
  - Block 1: the raw data, first=1, last=0.
  - Block 2: 0x80 at slot 0, [63:0]=0x200, last=1.
- Backpressure: hold blk_ready=0 for 5 cycles with blk_valid=1.
  - blk_data is unchanged and in_ready=0 throughout.
  - After release, one handshake occurs and in_ready=1 on the next cycle.
- Reset and back-to-back messages:
  - Pull reset_n low after 10 bytes of a message. Outputs go to reset values immediately.
  - Then send "abc" followed immediately by "abc": two identical blocks, each with first=last=1.
